tour_sequencer: RTL and testbench

TOUR_SEQUENCER -- requirements
Module: tour_sequencer

---
 rtl/tour_sequencer.sv | 148 ++++++++++++++
 tb/tb_tour_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tour_sequencer.sv
// Replays a 24-move knight's tour as vertical then horizontal drive commands.
// Outside a tour, the UART command path is passed straight through to the command processor.
module tour_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0]  LastIdx    = 5'd23;
  localparam logic [3:0]  OpMove     = 4'b0010;
  localparam logic [3:0]  OpFanfare  = 4'b0011;
  localparam logic [7:0]  HeadNorth  = 8'h00;
  localparam logic [7:0]  HeadSouth  = 8'h7F;
  localparam logic [7:0]  HeadEast   = 8'hBF;
  localparam logic [7:0]  HeadWest   = 8'h3F;
  localparam logic [7:0]  RespDone   = 8'hA5;
  localparam logic [7:0]  RespBusy   = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StVert,
    StHoldV,
    StHorz,
    StHoldH
  } state_e;

  state_e      state_q;
  logic [15:0] hold_cmd_q;

  logic        move_ok;
  logic        dx_neg;
  logic        dy_neg;
  logic [1:0]  dx_mag;
  logic [1:0]  dy_mag;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        last_move;

  // Knight move decode; anything that is not exactly one-hot is invalid.
  always_comb begin
    move_ok = 1'b1;
    dx_neg  = 1'b0;
    dy_neg  = 1'b0;
    dx_mag  = 2'd0;
    dy_mag  = 2'd0;
    case (move)
      8'h01: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'h02: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'h04: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      8'h08: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'h10: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'h20: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'h40: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      8'h80: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      default: move_ok = 1'b0;
    endcase
  end

  assign vert_cmd  = {OpMove, dy_neg ? HeadSouth : HeadNorth, 2'b00, dy_mag};
  assign horz_cmd  = {OpFanfare, dx_neg ? HeadWest : HeadEast, 2'b00, dx_mag};
  assign last_move = (mv_indx == LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mv_indx    <= 5'd0;
      hold_cmd_q <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_tour) begin
            mv_indx <= 5'd0;
            state_q <= StVert;
          end
        end
        StVert: begin
          if (!move_ok) begin
            state_q <= StIdle;
          end else begin
            // Captured so the hold state keeps presenting the issued command.
            hold_cmd_q <= vert_cmd;
            if (clr_cmd_rdy) state_q <= StHoldV;
          end
        end
        StHoldV: begin
          if (send_resp) state_q <= StHorz;
        end
        StHorz: begin
          if (!move_ok) begin
            state_q <= StIdle;
          end else begin
            hold_cmd_q <= horz_cmd;
            if (clr_cmd_rdy) state_q <= StHoldH;
          end
        end
        StHoldH: begin
          if (send_resp) begin
            if (last_move) begin
              state_q <= StIdle;
            end else begin
              mv_indx <= mv_indx + 5'd1;
              state_q <= StVert;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cmd              = hold_cmd_q;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RespBusy;
    unique case (state_q)
      StIdle: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RespDone;
      end
      StVert: begin
        cmd     = vert_cmd;
        cmd_rdy = move_ok;
      end
      StHorz: begin
        cmd     = horz_cmd;
        cmd_rdy = move_ok;
      end
      StHoldH: begin
        resp = last_move ? RespDone : RespBusy;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tour_sequencer.sv
// Randomised bench for tour_sequencer against a move-table reference model.
module tb_tour_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_rises = 0;
  bit count_en = 1'b0;
  logic rdy_prev = 1'b0;

  // Knight displacement per move bit.
  localparam int DX [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  localparam int DY [8] = '{2, 2, 1, -1, -2, -2, 1, -1};

  tour_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (count_en && cmd_rdy && !rdy_prev) rdy_rises++;
    rdy_prev = cmd_rdy;
  end

  function automatic logic [15:0] exp_vert(input int k);
    int d;
    d = DY[k];
    return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'((d < 0) ? -d : d)};
  endfunction

  function automatic logic [15:0] exp_horz(input int k);
    int d;
    d = DX[k];
    return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'((d < 0) ? -d : d)};
  endfunction

  task automatic begin_tour();
    @(negedge clk);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  // Entered at a negedge in VERT; returns at a negedge after the move (or in HOLD_H).
  task automatic tour_step(input int idx, input int k, input bit last, input bit finish);
    int waits;
    move = 8'(1 << k);
    #1;
    n_tests++; if (cmd !== exp_vert(k)) begin n_fail++;
      $display("FAIL vert_cmd idx=%0d got %h want %h", idx, cmd, exp_vert(k)); end
    n_tests++; if (cmd_rdy !== 1'b1) begin n_fail++;
      $display("FAIL vert_rdy idx=%0d got %b want 1", idx, cmd_rdy); end
    n_tests++; if (mv_indx !== 5'(idx)) begin n_fail++;
      $display("FAIL mv_indx got %0d want %0d", mv_indx, idx); end
    n_tests++; if (resp !== 8'h5A) begin n_fail++;
      $display("FAIL vert_resp idx=%0d got %h want 5a", idx, resp); end
    waits = $urandom_range(2);
    repeat (waits) begin
      send_resp = 1'($urandom_range(1));
      @(negedge clk); send_resp = 1'b0; #1;
      n_tests++; if (cmd_rdy !== 1'b1 || cmd !== exp_vert(k)) begin n_fail++;
        $display("FAIL vert_wait idx=%0d got %b/%h want 1/%h", idx, cmd_rdy, cmd, exp_vert(k)); end
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0; #1;
    n_tests++; if (cmd_rdy !== 1'b0 || cmd !== exp_vert(k)) begin n_fail++;
      $display("FAIL hold_v idx=%0d got %b/%h want 0/%h", idx, cmd_rdy, cmd, exp_vert(k)); end
    waits = $urandom_range(2);
    repeat (waits) begin
      clr_cmd_rdy = 1'($urandom_range(1));
      @(negedge clk); clr_cmd_rdy = 1'b0; #1;
      n_tests++; if (cmd_rdy !== 1'b0 || cmd !== exp_vert(k)) begin n_fail++;
        $display("FAIL hold_v_wait idx=%0d got %b/%h want 0/%h", idx, cmd_rdy, cmd, exp_vert(k)); end
    end
    send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; #1;
    n_tests++; if (cmd !== exp_horz(k) || cmd_rdy !== 1'b1) begin n_fail++;
      $display("FAIL horz idx=%0d got %b/%h want 1/%h", idx, cmd_rdy, cmd, exp_horz(k)); end
    n_tests++; if (resp !== 8'h5A) begin n_fail++;
      $display("FAIL horz_resp idx=%0d got %h want 5a", idx, resp); end
    clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0; #1;
    n_tests++; if (cmd_rdy !== 1'b0 || mv_indx !== 5'(idx)) begin n_fail++;
      $display("FAIL hold_h idx=%0d got rdy %b idx %0d want 0/%0d", idx, cmd_rdy, mv_indx, idx); end
    n_tests++; if (resp !== (last ? 8'hA5 : 8'h5A)) begin n_fail++;
      $display("FAIL hold_h_resp idx=%0d got %h want %h", idx, resp, last ? 8'hA5 : 8'h5A); end
    if (finish) begin
      send_resp = 1'b1;
      @(negedge clk); send_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_tour = 1'b0; move = 8'h00; cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    #12;
    n_tests++; if (mv_indx !== 5'd0 || resp !== 8'hA5) begin n_fail++;
      $display("FAIL reset got idx %0d resp %h want 0/a5", mv_indx, resp); end
    n_tests++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b0) begin n_fail++;
      $display("FAIL reset_mux got %h/%b want 1234/0", cmd, cmd_rdy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_idle_passthrough();
    logic [15:0] c;
    logic r, k;
    @(negedge clk);
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
    n_tests++; if (cmd !== 16'h2003 || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1) begin
      n_fail++; $display("FAIL idle_pass got %h/%b/%b want 2003/1/1", cmd, cmd_rdy, clr_cmd_rdy_UART); end
    n_tests++; if (resp !== 8'hA5) begin n_fail++;
      $display("FAIL idle_resp got %h want a5", resp); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c = 16'($urandom); r = 1'($urandom_range(1)); k = 1'($urandom_range(1));
      cmd_UART = c; cmd_rdy_UART = r; clr_cmd_rdy = k; #1;
      n_tests++; if (cmd !== c || cmd_rdy !== r || clr_cmd_rdy_UART !== k) begin n_fail++;
        $display("FAIL idle_rand got %h/%b/%b want %h/%b/%b", cmd, cmd_rdy, clr_cmd_rdy_UART, c, r, k); end
    end
    @(negedge clk); cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_directed_moves();
    cmd_UART = 16'hFFFF;
    begin_tour();
    move = 8'h01; #1;
    n_tests++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b1) begin n_fail++;
      $display("FAIL move01_vert got %h/%b want 2002/1", cmd, cmd_rdy); end
    tour_step(0, 0, 1'b0, 1'b1);
    move = 8'h80; #1;
    n_tests++; if (cmd !== 16'h27F1) begin n_fail++;
      $display("FAIL move80_vert got %h want 27f1", cmd); end
    tour_step(1, 7, 1'b0, 1'b1);
    // Empty move aborts straight back to passthrough.
    move = 8'h00; #1;
    n_tests++; if (cmd_rdy !== 1'b0) begin n_fail++;
      $display("FAIL abort_rdy got %b want 0", cmd_rdy); end
    @(negedge clk); cmd_UART = 16'h0BAD; #1;
    n_tests++; if (resp !== 8'hA5 || cmd !== 16'h0BAD) begin n_fail++;
      $display("FAIL abort_idle got %h/%h want a5/0bad", resp, cmd); end
  endtask

  task automatic test_abort_horz();
    begin_tour();
    move = 8'h04; clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; move = 8'h03; cmd_rdy_UART = 1'b1; #1;
    n_tests++; if (cmd_rdy !== 1'b0 || clr_cmd_rdy_UART !== 1'b0) begin n_fail++;
      $display("FAIL abort_horz got %b/%b want 0/0", cmd_rdy, clr_cmd_rdy_UART); end
    @(negedge clk); #1;
    n_tests++; if (cmd_rdy !== 1'b1 || resp !== 8'hA5) begin n_fail++;
      $display("FAIL abort_horz_idle got %b/%h want 1/a5", cmd_rdy, resp); end
    cmd_rdy_UART = 1'b0;
  endtask

  task automatic test_full_tour();
    int k;
    cmd_UART = 16'hFFFF;
    @(negedge clk);
    rdy_rises = 0; count_en = 1'b1;
    begin_tour();
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(7);
      tour_step(i, k, i == 23, 1'b1);
    end
    count_en = 1'b0;
    #3;
    n_tests++; if (rdy_rises !== 48) begin n_fail++;
      $display("FAIL rdy_count got %0d want 48", rdy_rises); end
    n_tests++; if (mv_indx > 5'd23) begin n_fail++;
      $display("FAIL idx_bound got %0d want <=23", mv_indx); end
    @(negedge clk);
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
    n_tests++; if (cmd !== 16'h2003 || cmd_rdy !== 1'b1 || clr_cmd_rdy_UART !== 1'b1
                   || resp !== 8'hA5) begin n_fail++;
      $display("FAIL post_tour got %h/%b/%b/%h want 2003/1/1/a5", cmd, cmd_rdy,
               clr_cmd_rdy_UART, resp); end
    @(negedge clk); cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_disturbances();
    int k;
    begin_tour();
    tour_step(0, $urandom_range(7), 1'b0, 1'b1);
    tour_step(1, $urandom_range(7), 1'b0, 1'b1);
    k = $urandom_range(7);
    move = 8'(1 << k); start_tour = 1'b1; cmd_rdy_UART = 1'b1; #1;
    n_tests++; if (clr_cmd_rdy_UART !== 1'b0) begin n_fail++;
      $display("FAIL disturb_clr got %b want 0", clr_cmd_rdy_UART); end
    @(negedge clk); start_tour = 1'b0; #1;
    n_tests++; if (mv_indx !== 5'd2 || cmd_rdy !== 1'b1 || cmd !== exp_vert(k)) begin n_fail++;
      $display("FAIL disturb_state got %0d/%b/%h want 2/1/%h", mv_indx, cmd_rdy, cmd, exp_vert(k)); end
    tour_step(2, k, 1'b0, 1'b0);
    start_tour = 1'b1; #1;
    n_tests++; if (clr_cmd_rdy_UART !== 1'b0 || resp !== 8'h5A) begin n_fail++;
      $display("FAIL disturb_hold got %b/%h want 0/5a", clr_cmd_rdy_UART, resp); end
    @(negedge clk); start_tour = 1'b0; #1;
    n_tests++; if (mv_indx !== 5'd2 || resp !== 8'h5A) begin n_fail++;
      $display("FAIL disturb_hold_state got %0d/%h want 2/5a", mv_indx, resp); end
    cmd_rdy_UART = 1'b0;
    send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; move = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_tour();
    cmd_UART = 16'hBEEF;
    begin_tour();
    for (int i = 0; i < 7; i++) tour_step(i, $urandom_range(7), 1'b0, 1'b1);
    tour_step(7, $urandom_range(7), 1'b0, 1'b0);
    #2 rst_n = 1'b0; #1;
    n_tests++; if (mv_indx !== 5'd0 || resp !== 8'hA5 || cmd !== 16'hBEEF) begin n_fail++;
      $display("FAIL reset_mid got %0d/%h/%h want 0/a5/beef", mv_indx, resp, cmd); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_resp = 1'b1; clr_cmd_rdy = 1'b1;
      @(negedge clk); #1;
      n_tests++; if (resp !== 8'hA5 || cmd !== 16'hBEEF || clr_cmd_rdy_UART !== 1'b1) begin
        n_fail++; $display("FAIL no_resume got %h/%h/%b want a5/beef/1", resp, cmd,
                           clr_cmd_rdy_UART); end
    end
    send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    begin_tour();
    tour_step(0, $urandom_range(7), 1'b0, 1'b1);
    move = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle_passthrough();
    test_directed_moves();
    test_abort_horz();
    test_full_tour();
    test_disturbances();
    test_reset_mid_tour();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
